// File: rtl/iqft_pkg.sv
// Shared types and constants for the sequential 4-point inverse QFT engine.
package iqft_pkg;

    localparam int N         = 4;
    localparam int FRAC_BITS = 5;
    localparam int DW        = 13;
    localparam int AW        = DW + 3;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    typedef logic signed [DW-1:0] din_t;
    typedef logic signed [AW-1:0] acc_t;

endpackage

// File: rtl/iqft_rot.sv
// Multiplies a complex sample by j^m, widening to accumulator width first
// so negating the most negative input is exact.
module iqft_rot
    import iqft_pkg::*;
(
    input  logic [1:0] m,
    input  din_t       in_re,
    input  din_t       in_im,
    output acc_t       out_re,
    output acc_t       out_im
);

    acc_t re_x;
    acc_t im_x;

    assign re_x = acc_t'(in_re);
    assign im_x = acc_t'(in_im);

    always_comb begin
        out_re = re_x;
        out_im = im_x;
        case (m)
            2'd0: begin out_re = re_x;  out_im = im_x;  end
            2'd1: begin out_re = -im_x; out_im = re_x;  end
            2'd2: begin out_re = -re_x; out_im = -im_x; end
            2'd3: begin out_re = im_x;  out_im = -re_x; end
            default: begin out_re = re_x; out_im = im_x; end
        endcase
    end

endmodule

// File: rtl/iqft_seq.sv
// Sequential 4-point inverse QFT: load 4 beats, 16-cycle shared-accumulator
// compute, stream 4 results. Define IQFT_SCALE_EN to divide results by 4.
module iqft_seq
    import iqft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic signed [AW-1:0] out_re,
    output logic signed [AW-1:0] out_im,
    output logic [1:0]       out_idx,
    output logic             busy
);

    state_e     state_q, state_d;
    logic [1:0] n_cnt_q, n_cnt_d;
    logic [1:0] k_cnt_q, k_cnt_d;
    logic [1:0] o_cnt_q, o_cnt_d;
    din_t       x_re_q [N];
    din_t       x_re_d [N];
    din_t       x_im_q [N];
    din_t       x_im_d [N];
    acc_t       acc_re_q, acc_re_d;
    acc_t       acc_im_q, acc_im_d;
    acc_t       res_re_q [N];
    acc_t       res_re_d [N];
    acc_t       res_im_q [N];
    acc_t       res_im_d [N];

    logic [1:0] rot_m;
    acc_t       rot_re, rot_im;
    acc_t       sum_re, sum_im;

    // Rounds half toward +inf when scaling is built in; identity otherwise.
    function automatic acc_t scale_res(input acc_t s);
`ifdef IQFT_SCALE_EN
        acc_t t;
        t = s + acc_t'(2);
        return t >>> 2;
`else
        return s;
`endif
    endfunction

    // (k*n) mod 4 only needs the low two product bits.
    assign rot_m = {(k_cnt_q[1] & n_cnt_q[0]) ^ (k_cnt_q[0] & n_cnt_q[1]),
                    k_cnt_q[0] & n_cnt_q[0]};

    iqft_rot u_rot (
        .m      (rot_m),
        .in_re  (x_re_q[n_cnt_q]),
        .in_im  (x_im_q[n_cnt_q]),
        .out_re (rot_re),
        .out_im (rot_im)
    );

    assign sum_re = ((n_cnt_q == 2'd0) ? acc_t'(0) : acc_re_q) + rot_re;
    assign sum_im = ((n_cnt_q == 2'd0) ? acc_t'(0) : acc_im_q) + rot_im;

    always_comb begin
        state_d  = state_q;
        n_cnt_d  = n_cnt_q;
        k_cnt_d  = k_cnt_q;
        o_cnt_d  = o_cnt_q;
        x_re_d   = x_re_q;
        x_im_d   = x_im_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        res_re_d = res_re_q;
        res_im_d = res_im_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    x_re_d[n_cnt_q] = in_re;
                    x_im_d[n_cnt_q] = in_im;
                    n_cnt_d         = n_cnt_q + 2'd1;
                    if (n_cnt_q == 2'd3) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_re_d = sum_re;
                acc_im_d = sum_im;
                n_cnt_d  = n_cnt_q + 2'd1;
                if (n_cnt_q == 2'd3) begin
                    res_re_d[k_cnt_q] = scale_res(sum_re);
                    res_im_d[k_cnt_q] = scale_res(sum_im);
                    k_cnt_d           = k_cnt_q + 2'd1;
                    if (k_cnt_q == 2'd3) state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    o_cnt_d = o_cnt_q + 2'd1;
                    if (o_cnt_q == 2'd3) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            n_cnt_q  <= '0;
            k_cnt_q  <= '0;
            o_cnt_q  <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            for (int i = 0; i < N; i++) begin
                x_re_q[i]   <= '0;
                x_im_q[i]   <= '0;
                res_re_q[i] <= '0;
                res_im_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            n_cnt_q  <= n_cnt_d;
            k_cnt_q  <= k_cnt_d;
            o_cnt_q  <= o_cnt_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            x_re_q   <= x_re_d;
            x_im_q   <= x_im_d;
            res_re_q <= res_re_d;
            res_im_q <= res_im_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != LOAD);
    assign out_idx   = o_cnt_q;
    assign out_re    = out_valid ? res_re_q[o_cnt_q] : acc_t'(0);
    assign out_im    = out_valid ? res_im_q[o_cnt_q] : acc_t'(0);

endmodule

// File: tb/tb_iqft_seq.sv
// Self-checking bench for iqft_seq: directed test-plan frames plus random
// frames checked against a complex-exponential reference model.
module tb_iqft_seq;
    import iqft_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] out_re;
    logic signed [AW-1:0] out_im;
    logic [1:0]           out_idx;
    logic                 busy;

    iqft_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_re[$];
    int exp_im[$];
    int exp_k = 0;
    int rdy_mode = 0;
    int bp_cnt = 0;
    int last_xfer_cyc = 0;
    int first_valid_cyc = -1;
    bit prev_valid = 1'b0;

    int vxr[4], vxi[4], vlr[4], vli[4], mr[4], mi[4];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int scl(input int v);
`ifdef IQFT_SCALE_EN
        return (v + 2) >>> 2;
`else
        return v;
`endif
    endfunction

    // out[k] = sum_n x[n] * e^(+j*pi/2*k*n), using cos/sin of quarter turns.
    task automatic model(input int xr[4], input int xi[4], output int er[4], output int ei[4]);
        int c[4];
        int s[4];
        c = '{1, 0, -1, 0};
        s = '{0, 1, 0, -1};
        for (int k = 0; k < 4; k++) begin
            int ar, ai;
            ar = 0;
            ai = 0;
            for (int n = 0; n < 4; n++) begin
                int m;
                m = (k * n) % 4;
                ar += xr[n] * c[m] - xi[n] * s[m];
                ai += xr[n] * s[m] + xi[n] * c[m];
            end
            er[k] = scl(ar);
            ei[k] = scl(ai);
        end
    endtask

    task automatic push_exp(input int er[4], input int ei[4]);
        for (int k = 0; k < 4; k++) begin
            exp_re.push_back(er[k]);
            exp_im.push_back(ei[k]);
        end
    endtask

    task automatic send_frame(input int xr[4], input int xi[4]);
        int n;
        int tries;
        n = 0;
        tries = 0;
        while (n < 4 && tries < 4000) begin
            @(negedge clk);
            tries++;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_re = din_t'(xr[n]);
                in_im = din_t'(xi[n]);
                if (in_ready) begin
                    last_xfer_cyc = cyc;
                    n++;
                end
            end
        end
        if (n < 4) check("input_accept_timeout", n, 4);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (exp_re.size() > 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (exp_re.size() > 0) begin
            check("drain_timeout_pending", exp_re.size(), 0);
            exp_re.delete();
            exp_im.delete();
            exp_k = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_directed(input string name, input int xr[4], input int xi[4],
                                input int lr[4], input int li[4]);
        int er[4], ei[4];
        model(xr, xi, er, ei);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_model_re%0d", name, k), er[k], lr[k]);
            check($sformatf("%s_model_im%0d", name, k), ei[k], li[k]);
        end
        push_exp(lr, li);
        send_frame(xr, xi);
        wait_drain(400);
    endtask

    // Output checker and consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                prev_valid = 1'b0;
            end else begin
                case (rdy_mode)
                    1: out_ready = 1'($urandom_range(0, 1));
                    2: begin
                        if (out_valid && out_idx == 2'd1 && bp_cnt < 5) begin
                            out_ready = 1'b0;
                            bp_cnt++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    default: out_ready = 1'b1;
                endcase
                if (out_valid && !prev_valid) first_valid_cyc = cyc;
                prev_valid = out_valid;
                if (out_valid) begin
                    if (exp_re.size() == 0) begin
                        check("spurious_out_valid", int'(out_valid), 0);
                    end else begin
                        check("out_idx", int'(out_idx), exp_k);
                        check($sformatf("out_re_k%0d", exp_k), int'(out_re), exp_re[0]);
                        check($sformatf("out_im_k%0d", exp_k), int'(out_im), exp_im[0]);
                        check("in_ready_while_output", int'(in_ready), 0);
                        check("busy_while_output", int'(busy), 1);
                        if (out_ready) begin
                            void'(exp_re.pop_front());
                            void'(exp_im.pop_front());
                            exp_k = (exp_k + 1) % 4;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rdy_mode = 0;
        vxr = '{32, 0, 0, 0}; vxi = '{0, 0, 0, 0}; vli = '{0, 0, 0, 0};
`ifdef IQFT_SCALE_EN
        vlr = '{8, 8, 8, 8};
`else
        vlr = '{32, 32, 32, 32};
`endif
        run_directed("impulse", vxr, vxi, vlr, vli);
        check("latency_first_output", first_valid_cyc - last_xfer_cyc, 17);

        vxr = '{32, 32, 32, 32};
`ifdef IQFT_SCALE_EN
        vlr = '{32, 0, 0, 0};
`else
        vlr = '{128, 0, 0, 0};
`endif
        run_directed("constant", vxr, vxi, vlr, vli);

        vxr = '{0, 32, 0, 0};
`ifdef IQFT_SCALE_EN
        vlr = '{8, 0, -8, 0}; vli = '{0, 8, 0, -8};
`else
        vlr = '{32, 0, -32, 0}; vli = '{0, 32, 0, -32};
`endif
        run_directed("shifted", vxr, vxi, vlr, vli);

        vxr = '{-4096, 4095, -4096, 4095}; vli = '{0, 0, 0, 0};
`ifdef IQFT_SCALE_EN
        vlr = '{0, 0, -4095, 0};
`else
        vlr = '{-2, 0, -16382, 0};
`endif
        run_directed("extreme_re", vxr, vxi, vlr, vli);

        vxr = '{0, 0, 0, 0}; vxi = '{-4096, -4096, -4096, -4096}; vlr = '{0, 0, 0, 0};
`ifdef IQFT_SCALE_EN
        vli = '{-4096, 0, 0, 0};
`else
        vli = '{-16384, 0, 0, 0};
`endif
        run_directed("extreme_im", vxr, vxi, vlr, vli);

        // Backpressure on idx 1 for five cycles.
        rdy_mode = 2;
        bp_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            vxr[n] = int'($urandom_range(0, 8191)) - 4096;
            vxi[n] = int'($urandom_range(0, 8191)) - 4096;
        end
        model(vxr, vxi, mr, mi);
        push_exp(mr, mi);
        send_frame(vxr, vxi);
        wait_drain(400);
        check("bp_stall_cycles", bp_cnt, 5);
        check("in_ready_after_frame", int'(in_ready), 1);

        // Abort a frame with reset in the 8th COMPUTE cycle.
        rdy_mode = 0;
        vxr = '{100, -200, 300, -400}; vxi = '{5, 6, 7, 8};
        send_frame(vxr, vxi);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_k = 0;
        @(negedge clk);
        check("post_reset_in_ready", int'(in_ready), 1);
        vxr = '{32, 0, 0, 0}; vxi = '{0, 0, 0, 0}; vli = '{0, 0, 0, 0};
`ifdef IQFT_SCALE_EN
        vlr = '{8, 8, 8, 8};
`else
        vlr = '{32, 32, 32, 32};
`endif
        run_directed("impulse_after_reset", vxr, vxi, vlr, vli);

        // Random back-to-back frames with random output readiness.
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            for (int n = 0; n < 4; n++) begin
                vxr[n] = int'($urandom_range(0, 8191)) - 4096;
                vxi[n] = int'($urandom_range(0, 8191)) - 4096;
            end
            model(vxr, vxi, mr, mi);
            push_exp(mr, mi);
            send_frame(vxr, vxi);
        end
        wait_drain(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
